// File: rtl/busarb.sv
// busarb: round-robin arbiter that lets NDOMAIN requesters share one bus controller.
// Define BUSARB_TIMEOUT_EN to compile in the ACCESS-state stall watchdog.
module busarb #(
    parameter int unsigned NDOMAIN     = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NDOMAIN-1:0]        dom_req,
    input  logic [NDOMAIN-1:0]        dom_we,
    input  logic [NDOMAIN*ADDR_W-1:0] dom_addr,
    input  logic [NDOMAIN*DATA_W-1:0] dom_wdata,
    output logic [NDOMAIN-1:0]        dom_ack,
    output logic [NDOMAIN-1:0]        dom_err,
    output logic [DATA_W-1:0]         dom_rdata,
    output logic                      bus_valid,
    input  logic                      bus_ready,
    output logic                      bus_we,
    output logic [ADDR_W-1:0]         bus_addr,
    output logic [DATA_W-1:0]         bus_data_in,
    input  logic [DATA_W-1:0]         bus_data_out,
    output logic                      busy
);

    localparam int unsigned GW = (NDOMAIN > 1) ? $clog2(NDOMAIN) : 1;
    localparam int unsigned CW = GW + 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              pick_found;
    logic [GW-1:0]     pick_idx;
    logic [CW-1:0]     cand;
    logic [NDOMAIN-1:0] grant_onehot;

`ifdef BUSARB_TIMEOUT_EN
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [16:0]       cnt_inc;

    assign cnt_inc = {1'b0, cnt_q} + 17'd1;
`endif

    // Scan upward from last_grant+1, wrapping modulo NDOMAIN; first requester wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NDOMAIN; i++) begin
            cand = {1'b0, last_grant_q} + CW'(i + 1);
            if (cand >= CW'(NDOMAIN)) begin
                cand = cand - CW'(NDOMAIN);
            end
            if (!pick_found && dom_req[cand[GW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
`ifdef BUSARB_TIMEOUT_EN
        err_d        = err_q;
        cnt_d        = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d = ACCESS;
                    grant_d = pick_idx;
                    we_d    = dom_we[pick_idx];
                    addr_d  = dom_addr[pick_idx*ADDR_W +: ADDR_W];
                    wdata_d = dom_wdata[pick_idx*DATA_W +: DATA_W];
`ifdef BUSARB_TIMEOUT_EN
                    err_d   = 1'b0;
                    cnt_d   = '0;
`endif
                end
            end
            ACCESS: begin
                // bus_ready takes priority over a watchdog expiry in the same cycle
                if (bus_ready) begin
                    rdata_d = we_q ? '0 : bus_data_out;
                    state_d = DONE;
                end
`ifdef BUSARB_TIMEOUT_EN
                else if (cnt_inc == 17'(TIMEOUT_CYC)) begin
                    rdata_d = '1;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_inc[15:0];
                end
`endif
            end
            DONE: begin
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NDOMAIN - 1);
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
`ifdef BUSARB_TIMEOUT_EN
            err_q        <= 1'b0;
            cnt_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
`ifdef BUSARB_TIMEOUT_EN
            err_q        <= err_d;
            cnt_q        <= cnt_d;
`endif
        end
    end

    assign grant_onehot = NDOMAIN'(1) << grant_q;

    assign bus_valid   = (state_q == ACCESS);
    assign bus_we      = bus_valid & we_q;
    assign bus_addr    = bus_valid ? addr_q : '0;
    assign bus_data_in = bus_valid ? wdata_q : '0;
    assign busy        = (state_q != IDLE);
    assign dom_rdata   = rdata_q;
    assign dom_ack     = (state_q == DONE) ? grant_onehot : '0;
`ifdef BUSARB_TIMEOUT_EN
    assign dom_err     = (state_q == DONE && err_q) ? grant_onehot : '0;
`else
    assign dom_err     = '0;
`endif

endmodule

// File: tb/tb_busarb.sv
// tb_busarb: directed vector table, hand-written corner sequences and a randomized run
// checked against a cycle-level reference model of the arbiter rules.
module tb_busarb;

    localparam int ND = 4;
    localparam int AW = 16;
    localparam int DW = 8;
    localparam int TO = 8;

    logic             clk;
    logic             reset;
    logic [ND-1:0]    dom_req, dom_we;
    logic [ND*AW-1:0] dom_addr;
    logic [ND*DW-1:0] dom_wdata;
    logic [ND-1:0]    dom_ack, dom_err;
    logic [DW-1:0]    dom_rdata;
    logic             bus_valid, bus_ready, bus_we, busy;
    logic [AW-1:0]    bus_addr;
    logic [DW-1:0]    bus_data_in, bus_data_out;

    int total = 0;
    int bad   = 0;

    busarb #(
        .NDOMAIN    (ND),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dom_req     (dom_req),
        .dom_we      (dom_we),
        .dom_addr    (dom_addr),
        .dom_wdata   (dom_wdata),
        .dom_ack     (dom_ack),
        .dom_err     (dom_err),
        .dom_rdata   (dom_rdata),
        .bus_valid   (bus_valid),
        .bus_ready   (bus_ready),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_data_in (bus_data_in),
        .bus_data_out(bus_data_out),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [3:0]    req;
        logic [3:0]    we;
        logic          rdy;
        logic [7:0]    dout;
        logic          e_valid;
        logic [15:0]   e_addr;
        logic [3:0]    e_ack;
        logic [7:0]    e_rdata;
        logic          e_busy;
    } vec_t;

    vec_t vecs[13];

    // Reference model state: phase 0 idle, 1 bus access, 2 completion.
    int            m_st, m_g, m_last, m_cnt;
    logic          m_we, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd, m_rd;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic set_base_fields();
        for (int d = 0; d < ND; d++) begin
            dom_addr[d*AW +: AW]  = 16'h0010 + 16'(d * 16'h1000);
            dom_wdata[d*DW +: DW] = 8'h11 * 8'(d + 1);
        end
        dom_we = '0;
    endtask

    task automatic model_tick();
        bit found;
        if (reset) begin
            m_st = 0; m_last = ND - 1; m_rd = '0; m_err = 1'b0; m_cnt = 0;
        end else begin
            case (m_st)
                0: begin
                    found = 0;
                    for (int i = 1; i <= ND; i++) begin
                        int d;
                        d = (m_last + i) % ND;
                        if (!found && dom_req[d]) begin
                            found  = 1;
                            m_g    = d;
                            m_we   = dom_we[d];
                            m_addr = dom_addr[d*AW +: AW];
                            m_wd   = dom_wdata[d*DW +: DW];
                        end
                    end
                    if (found) begin
                        m_st = 1; m_cnt = 0; m_err = 1'b0;
                    end
                end
                1: begin
                    if (bus_ready) begin
                        m_rd = m_we ? '0 : bus_data_out;
                        m_st = 2;
                    end else begin
                        m_cnt++;
`ifdef BUSARB_TIMEOUT_EN
                        if (m_cnt == TO) begin
                            m_rd = '1; m_err = 1'b1; m_st = 2;
                        end
`endif
                    end
                end
                default: begin
                    m_last = m_g;
                    m_st   = 0;
                end
            endcase
        end
    endtask

    function automatic logic [63:0] model_outs();
        logic          v;
        logic [ND-1:0] ack, err;
        v   = (m_st == 1);
        ack = (m_st == 2) ? ND'(1) << m_g : '0;
        err = (m_st == 2 && m_err) ? ND'(1) << m_g : '0;
        return 64'({v, v & m_we, v ? m_addr : 16'h0, v ? m_wd : 8'h0, ack, err, m_rd,
                    m_st != 0});
    endfunction

    initial begin
        reset = 1'b1; dom_req = '0; bus_ready = 1'b0; bus_data_out = '0;
        set_base_fields();

        //            rst   req   we    rdy   dout   valid addr     ack   rdata  busy
        vecs[0]  = '{1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 16'h0000, 4'h0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 4'h1, 4'h0, 1'b1, 8'h5A, 1'b1, 16'h0010, 4'h0, 8'h00, 1'b1};
        vecs[2]  = '{1'b0, 4'h1, 4'h0, 1'b1, 8'h5A, 1'b0, 16'h0000, 4'h1, 8'h5A, 1'b1};
        vecs[3]  = '{1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 16'h0000, 4'h0, 8'h5A, 1'b0};
        vecs[4]  = '{1'b0, 4'h2, 4'h0, 1'b0, 8'h00, 1'b1, 16'h1010, 4'h0, 8'h5A, 1'b1};
        vecs[5]  = '{1'b0, 4'h2, 4'h0, 1'b0, 8'h00, 1'b1, 16'h1010, 4'h0, 8'h5A, 1'b1};
        vecs[6]  = '{1'b1, 4'h2, 4'h0, 1'b1, 8'h99, 1'b0, 16'h0000, 4'h0, 8'h00, 1'b0};
        vecs[7]  = '{1'b0, 4'h3, 4'h0, 1'b0, 8'h00, 1'b1, 16'h0010, 4'h0, 8'h00, 1'b1};
        vecs[8]  = '{1'b0, 4'h3, 4'h0, 1'b1, 8'h77, 1'b0, 16'h0000, 4'h1, 8'h77, 1'b1};
        vecs[9]  = '{1'b0, 4'h2, 4'h0, 1'b0, 8'h00, 1'b0, 16'h0000, 4'h0, 8'h77, 1'b0};
        vecs[10] = '{1'b0, 4'h2, 4'h0, 1'b0, 8'h00, 1'b1, 16'h1010, 4'h0, 8'h77, 1'b1};
        vecs[11] = '{1'b0, 4'h2, 4'h2, 1'b1, 8'h66, 1'b0, 16'h0000, 4'h2, 8'h66, 1'b1};
        vecs[12] = '{1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 16'h0000, 4'h0, 8'h66, 1'b0};

        for (int i = 0; i < 13; i++) begin
            reset = vecs[i].rst; dom_req = vecs[i].req; dom_we = vecs[i].we;
            bus_ready = vecs[i].rdy; bus_data_out = vecs[i].dout;
            step();
            chk($sformatf("vec%0d", i),
                64'({bus_valid, bus_addr, dom_ack, dom_rdata, busy, dom_err}),
                64'({vecs[i].e_valid, vecs[i].e_addr, vecs[i].e_ack, vecs[i].e_rdata,
                     vecs[i].e_busy, 4'h0}));
        end

        // Domain 1 write held off by four stalled cycles; inputs change after latch.
        dom_addr[AW +: AW] = 16'h1234; dom_wdata[DW +: DW] = 8'hC3; dom_we = 4'b0010;
        dom_req = 4'b0010; bus_ready = 1'b0;
        step();
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("wr_hold%0d", k), 64'({bus_valid, bus_we, bus_addr, bus_data_in}),
                64'({1'b1, 1'b1, 16'h1234, 8'hC3}));
            dom_addr[AW +: AW] = 16'hBEEF; dom_wdata[DW +: DW] = 8'h00; dom_we = 4'b0000;
            bus_ready = (k == 5);
            step();
        end
        chk("wr_done", 64'({dom_ack, dom_rdata, bus_valid}), 64'({4'b0010, 8'h00, 1'b0}));
        dom_req = '0; bus_ready = 1'b0;
        set_base_fields();
        step();

        // last_grant is 1: requests on 3 and 1 must go 3 first, then 1.
        dom_req = 4'b1010; bus_ready = 1'b1; bus_data_out = 8'h21;
        step();
        chk("rr_first", 64'(bus_addr), 64'(16'h3010));
        step();
        chk("rr_ack3", 64'(dom_ack), 64'(4'b1000));
        dom_req = 4'b0010;
        step();
        step();
        chk("rr_second", 64'(bus_addr), 64'(16'h1010));
        step();
        chk("rr_ack1", 64'(dom_ack), 64'(4'b0010));
        dom_req = '0;
        step();

        // Two domains requesting continuously alternate, one ack every third cycle.
        reset = 1'b1;
        step();
        reset = 1'b0; dom_req = 4'b0011;
        for (int c = 1; c <= 12; c++) begin
            step();
            chk($sformatf("alt%0d", c), 64'(dom_ack),
                64'((c % 3 == 2) ? (((c / 3) % 2 == 0) ? 4'b0001 : 4'b0010) : 4'b0000));
        end
        dom_req = '0;
        step();
        step();

`ifdef BUSARB_TIMEOUT_EN
        dom_req = 4'b0100; bus_ready = 1'b0;
        step();
        for (int k = 1; k <= TO; k++) begin
            chk($sformatf("to_wait%0d", k), 64'({bus_valid, dom_ack}), 64'({1'b1, 4'b0}));
            step();
        end
        chk("to_expire", 64'({bus_valid, dom_ack, dom_err, dom_rdata}),
            64'({1'b0, 4'b0100, 4'b0100, 8'hFF}));
        dom_req = '0;
        step();
        dom_req = 4'b0100; bus_data_out = 8'h3C;
        step();
        for (int k = 1; k <= TO; k++) begin
            bus_ready = (k == TO);
            step();
        end
        chk("to_race", 64'({dom_ack, dom_err, dom_rdata}), 64'({4'b0100, 4'b0000, 8'h3C}));
`else
        dom_req = 4'b0100; bus_ready = 1'b0;
        step();
        for (int k = 1; k <= 20; k++) begin
            chk($sformatf("stall%0d", k), 64'({bus_valid, dom_ack, dom_err}),
                64'({1'b1, 4'b0, 4'b0}));
            step();
        end
        bus_ready = 1'b1; bus_data_out = 8'h3C;
        step();
        chk("stall_end", 64'({dom_ack, dom_err, dom_rdata}), 64'({4'b0100, 4'b0000, 8'h3C}));
`endif
        dom_req = '0; bus_ready = 1'b0;
        step();

        // Randomized traffic against the reference model.
        for (int n = 0; n < 4000; n++) begin
            reset = (n == 0) || ($urandom_range(0, 149) == 0);
            for (int d = 0; d < ND; d++) begin
                if (!dom_req[d]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        dom_req[d]            = 1'b1;
                        dom_we[d]             = 1'($urandom);
                        dom_addr[d*AW +: AW]  = 16'($urandom);
                        dom_wdata[d*DW +: DW] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 7) == 0) begin
                    dom_we[d]             = 1'($urandom);
                    dom_addr[d*AW +: AW]  = 16'($urandom);
                    dom_wdata[d*DW +: DW] = 8'($urandom);
                end else if (m_st == 1 && m_g == d && $urandom_range(0, 15) == 0) begin
                    dom_req[d] = 1'b0;
                end
            end
            bus_ready    = (n < 2000) ? 1'($urandom) : ($urandom_range(0, 9) == 0);
            bus_data_out = 8'($urandom);
            model_tick();
            step();
            chk($sformatf("rand%0d", n),
                64'({bus_valid, bus_we, bus_addr, bus_data_in, dom_ack, dom_err, dom_rdata,
                     busy}),
                model_outs());
            if (m_st == 2) dom_req[m_g] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
